// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo - multiply/divide unit with architectural HI/LO registers.
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage. Multiply and divide
// results are computed in full on the sampling edge and parked in pending
// registers; a down-counter then holds Busy high for MULT_CYCLES/DIV_CYCLES
// cycles, and HI/LO are committed together on the terminal-count edge.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; clears all state
//   Start    in   operation strobe, one cycle per instruction
//   MdOp     in   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   A        in   rs operand (dividend / multiplicand / mt* source)
//   B        in   rt operand (divisor / multiplier)
//   HiLoSel  in   Out mux: 1 selects HI, 0 selects LO
//   Abort    in   exception flush (only when MDU_ABORT_EN is defined)
//   Busy     out  multi-cycle operation in flight
//   Hi, Lo   out  architectural HI/LO
//   Out      out  HiLoSel ? Hi : Lo, combinational
//
// Optional feature macro: MDU_ABORT_EN adds the Abort input. Without it an
// operation in flight always commits.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting Start; mt* writes HI/LO directly
// RUN    | counting down; Start ignored; commit pending HI/LO at count 1->0
// -----------------------------------------------------------------------------
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoSel,
`ifdef MDU_ABORT_EN
    input  logic        Abort,
`endif
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] Out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     pend_hi_q;
    logic [31:0]     pend_lo_q;
    logic            pend_wr_q;

    logic            abort_w;

`ifdef MDU_ABORT_EN
    assign abort_w = Abort;
`else
    assign abort_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the live operands every cycle and
    // captured only when an operation is accepted in IDLE.
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] pend_hi_d;
    logic [31:0] pend_lo_d;
    logic        pend_wr_d;
    logic [CW-1:0] cnt_load_d;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide goes through magnitudes so that 0x80000000 / -1 has a
    // well-defined result (quotient wraps back to 0x80000000, remainder 0).
    assign div_signed = (MdOp == OP_DIV);
    assign a_mag      = A[31] ? (32'd0 - A) : A;
    assign b_mag      = B[31] ? (32'd0 - B) : B;
    assign num        = div_signed ? a_mag : A;
    assign den        = div_signed ? b_mag : B;
    // Divide by zero never commits; the substitute divisor only keeps the
    // divider free of undefined values.
    assign den_safe   = (den == 32'd0) ? 32'd1 : den;
    assign q_mag      = num / den_safe;
    assign r_mag      = num % den_safe;
    assign quot       = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem        = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        pend_hi_d  = 32'd0;
        pend_lo_d  = 32'd0;
        pend_wr_d  = 1'b0;
        cnt_load_d = '0;
        case (MdOp)
            OP_MULT: begin
                pend_hi_d  = prod_s[63:32];
                pend_lo_d  = prod_s[31:0];
                pend_wr_d  = 1'b1;
                cnt_load_d = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
                pend_hi_d  = prod_u[63:32];
                pend_lo_d  = prod_u[31:0];
                pend_wr_d  = 1'b1;
                cnt_load_d = CW'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                pend_hi_d  = rem;
                pend_lo_d  = quot;
                pend_wr_d  = (B != 32'd0);
                cnt_load_d = CW'(DIV_CYCLES);
            end
            default: begin
                pend_hi_d  = 32'd0;
                pend_lo_d  = 32'd0;
                pend_wr_d  = 1'b0;
                cnt_load_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and architectural state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A flush in the same cycle drops the Start, mt* included.
                    if (Start && !abort_w) begin
                        case (MdOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_hi_q <= pend_hi_d;
                                pend_lo_q <= pend_lo_d;
                                pend_wr_q <= pend_wr_d;
                                cnt_q     <= cnt_load_d;
                                busy_q    <= 1'b1;
                                state_q   <= S_RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (abort_w) begin
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        pend_hi_q <= 32'd0;
                        pend_lo_q <= 32'd0;
                        pend_wr_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == CW'(1)) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        pend_hi_q <= 32'd0;
                        pend_lo_q <= 32'd0;
                        pend_wr_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Out  = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

    localparam int LIMIT = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoSel;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [31:0] Out;
`ifdef MDU_ABORT_EN
    logic        Abort;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MdOp    (MdOp),
        .A       (A),
        .B       (B),
        .HiLoSel (HiLoSel),
`ifdef MDU_ABORT_EN
        .Abort   (Abort),
`endif
        .Busy    (Busy),
        .Hi      (Hi),
        .Lo      (Lo),
        .Out     (Out)
    );

    always #5 clk = ~clk;

    // Reference model: architectural effect of one accepted operation.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      la, lb, p, q, r;
        logic [63:0] pu;
        sa = a; sb = b;
        la = sa; lb = sb;
        case (op)
            3'd1: begin p = la * lb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin pu = {32'd0, a} * {32'd0, b}; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
            3'd3: if (b != 0) begin q = la / lb; r = la % lb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            3'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    function automatic int cycles_of(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Issue one op; optionally inject a (to-be-ignored) Start on busy cycle inj.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj, input logic [2:0] inj_op,
                          input logic [31:0] inj_a);
        logic [31:0] old_hi, old_lo;
        int n, cnt;
        old_hi = exp_hi; old_lo = exp_lo;
        Start = 1'b1; MdOp = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; MdOp = 3'd0; A = $urandom; B = $urandom;
        n = cycles_of(op);
        model(op, a, b);
        if (n == 0) begin
            n_checks++;
            if (Busy !== 1'b0) begin
                n_fail++; $display("FAIL %s busy: got %b expected 0", nm, Busy);
            end
        end else begin
            n_checks++;
            if (Hi !== old_hi || Lo !== old_lo) begin
                n_fail++;
                $display("FAIL %s early_commit: got %h_%h expected %h_%h", nm, Hi, Lo, old_hi, old_lo);
            end
            cnt = 0;
            while (Busy === 1'b1 && cnt < LIMIT) begin
                cnt++;
                if (cnt == inj) begin Start = 1'b1; MdOp = inj_op; A = inj_a; end
                @(posedge clk); #1;
                Start = 1'b0; MdOp = 3'd0;
            end
            n_checks++;
            if (cnt != n) begin
                n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, cnt, n);
            end
        end
        n_checks++;
        if (Hi !== exp_hi || Lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", nm, Hi, Lo, exp_hi, exp_lo);
        end
        HiLoSel = 1'b1; #1;
        n_checks++;
        if (Out !== exp_hi) begin
            n_fail++; $display("FAIL %s out_hi: got %h expected %h", nm, Out, exp_hi);
        end
        HiLoSel = 1'b0; #1;
        n_checks++;
        if (Out !== exp_lo) begin
            n_fail++; $display("FAIL %s out_lo: got %h expected %h", nm, Out, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; MdOp = 3'd0; A = 32'd0; B = 32'd0; HiLoSel = 1'b0;
`ifdef MDU_ABORT_EN
        Abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0 || Out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h out=%h expected all 0", Busy, Hi, Lo, Out);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_directed();
        run_op("mult_neg", 3'd1, 32'hFFFFFFFF, 32'd2, 0, 3'd0, 32'd0);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0, 3'd0, 32'd0);
        run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 3'd0, 32'd0);
        run_op("mthi", 3'd5, 32'h1234, 32'd0, 0, 3'd0, 32'd0);
        run_op("divu_zero", 3'd4, 32'd5, 32'd0, 0, 3'd0, 32'd0);
        run_op("div_zero", 3'd3, 32'hDEAD0001, 32'd0, 0, 3'd0, 32'd0);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 32'd0);
        run_op("div_nn", 3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 3'd0, 32'd0);
        run_op("mtlo", 3'd6, 32'hCAFE0000, 32'd0, 0, 3'd0, 32'd0);
        run_op("nop7", 3'd7, 32'h11111111, 32'd3, 0, 3'd0, 32'd0);
    endtask

    task automatic test_ignore_start();
        run_op("div_ign", 3'd3, 32'd100, 32'd7, 3, 3'd6, 32'hAAAA);
        n_checks++;
        if (Lo === 32'hAAAA) begin
            n_fail++; $display("FAIL ign_lo: got %h expected not 0000aaaa", Lo);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_1", 3'd2, 32'h0001_0000, 32'h0001_0000, 0, 3'd0, 32'd0);
        run_op("b2b_2", 3'd4, 32'd1000, 32'd33, 0, 3'd0, 32'd0);
        run_op("b2b_3", 3'd5, 32'h7777_0001, 32'd0, 0, 3'd0, 32'd0);
        run_op("b2b_4", 3'd1, 32'h8000_0000, 32'h8000_0000, 0, 3'd0, 32'd0);
    endtask

    task automatic test_random();
        logic [2:0]  op, iop;
        logic [31:0] a, b;
        int          inj;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? (32'd0 - 32'($urandom_range(1, 9))) : $urandom;
            iop = 3'($urandom_range(0, 7));
            inj = ($urandom_range(0, 1) == 1 && cycles_of(op) > 0) ? $urandom_range(1, cycles_of(op)) : 0;
            run_op("rand", op, a, b, inj, iop, $urandom);
        end
    endtask

    task automatic test_reset_midrun();
        run_op("pre_rst_hi", 3'd5, 32'h0BAD_F00D, 32'd0, 0, 3'd0, 32'd0);
        run_op("pre_rst_lo", 3'd6, 32'h0000_BEEF, 32'd0, 0, 3'd0, 32'd0);
        Start = 1'b1; MdOp = 3'd1; A = 32'd9; B = 32'd9;
        @(posedge clk); #1;
        Start = 1'b0; MdOp = 3'd0;
        @(posedge clk); #3;
        reset = 1'b1; #1;
        HiLoSel = 1'b1; #1;
        n_checks++;
        if (Busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0 || Out !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b hi=%h lo=%h out=%h expected all 0", Busy, Hi, Lo, Out);
        end
        HiLoSel = 1'b0;
        @(negedge clk); reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (Busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin
                n_fail++;
                $display("FAIL post_reset_commit: got busy=%b hi=%h lo=%h expected all 0", Busy, Hi, Lo);
            end
        end
    endtask

    task automatic test_abort();
`ifdef MDU_ABORT_EN
        run_op("ab_pre_hi", 3'd5, 32'h5555, 32'd0, 0, 3'd0, 32'd0);
        run_op("ab_pre_lo", 3'd6, 32'h6666, 32'd0, 0, 3'd0, 32'd0);
        Start = 1'b1; MdOp = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        Start = 1'b0; MdOp = 3'd0;
        @(posedge clk); #1;
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
            n_fail++;
            $display("FAIL abort_run: got busy=%b hi=%h lo=%h expected 0 %h %h", Busy, Hi, Lo, exp_hi, exp_lo);
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
            n_fail++;
            $display("FAIL abort_late_commit: got busy=%b hi=%h lo=%h expected 0 %h %h", Busy, Hi, Lo, exp_hi, exp_lo);
        end
        Start = 1'b1; MdOp = 3'd5; A = 32'h9999; Abort = 1'b1;
        @(posedge clk); #1;
        MdOp = 3'd1;
        @(posedge clk); #1;
        Start = 1'b0; MdOp = 3'd0; Abort = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
            n_fail++;
            $display("FAIL abort_idle_drop: got busy=%b hi=%h lo=%h expected 0 %h %h", Busy, Hi, Lo, exp_hi, exp_lo);
        end
`else
        run_op("noabort_mult", 3'd1, 32'd3, 32'd4, 0, 3'd0, 32'd0);
        n_checks++;
        if (Lo !== 32'd12) begin
            n_fail++; $display("FAIL noabort_lo: got %h expected 0000000c", Lo);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
